irq_arbiter: RTL and testbench

Interrupt priority arbiter and sequencer between the interrupt sources and the core's trap path (Zicsr). It latches 16 external lines plus the timer line into pending bits and masks them with a software-programmable enable register. It selects one winner by fixed priority, presents it to the core with a request/ack handshake, and holds further maskable interrupts until the handler signals completion. NMI bypasses masking and the in-service lock. Registers are reachable through the peripheral bus port.

---
 rtl/irq_arbiter_if.sv | 25 ++
 rtl/irq_arbiter.sv | 135 +++++++++++++
 tb/tb_irq_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_arbiter_if.sv
// Register bus and core trap handshake between irq_arbiter and its host.
// The master drives accesses and acks. The slave (the arbiter) answers them.
interface irq_arbiter_if;
   logic [1:0]  reg_addr;
   logic        reg_write;
   logic [31:0] reg_wdata;
   logic        reg_read;
   logic [31:0] reg_rdata;
   logic        irq_valid;
   logic [4:0]  irq_id;
   logic        irq_nmi;
   logic        irq_ack;
   logic        irq_complete;
   logic [4:0]  complete_id;

   modport master (
      output reg_addr, reg_write, reg_wdata, reg_read, irq_ack, irq_complete, complete_id,
      input  reg_rdata, irq_valid, irq_id, irq_nmi
   );

   modport slave (
      input  reg_addr, reg_write, reg_wdata, reg_read, irq_ack, irq_complete, complete_id,
      output reg_rdata, irq_valid, irq_id, irq_nmi
   );
endinterface

// File: rtl/irq_arbiter.sv
// Fixed-priority interrupt arbiter: pending/enable registers, request/ack/complete sequencing
// and an NMI path that ignores masking and the in-service lock.
module irq_arbiter #(
   parameter int                 NUM_EXT   = 16,
   parameter logic [NUM_EXT-1:0] EDGE_MASK = 16'h0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_EXT-1:0] externalInterrupts,
   input  logic               timerInterrupt,
   input  logic               NMI,
   irq_arbiter_if.slave       bus
);
   localparam int NUM_SRC = NUM_EXT + 1;

   // IDLE: nothing offered | REQ: presenting irq_id | WAIT: handler running, maskables locked
   typedef enum logic [1:0] {IDLE, REQ, WAIT} arbState_e;

   arbState_e          state;
   logic [NUM_SRC-1:0] enable;
   logic [NUM_SRC-1:0] pending;
   logic [NUM_SRC-1:0] pendingNext;
   logic [NUM_EXT-1:0] extPrev;
   logic               nmiPrev;
   logic               nmiPend;
   logic [4:0]         inService;
   logic [4:0]         winner;
   logic               nmiEdge;
   logic               nmiAck;
   logic               maskAck;
   logic               unusedWdata;

   assign unusedWdata = ^bus.reg_wdata[31:NUM_SRC];

   function automatic logic [4:0] lowestId(input logic [NUM_SRC-1:0] p);
      lowestId = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (p[i]) lowestId = 5'(i + 1);
      end
   endfunction

   always_comb begin
      nmiEdge     = NMI & ~nmiPrev;
      nmiAck      = bus.irq_ack & bus.irq_nmi;
      maskAck     = bus.irq_ack & ~bus.irq_nmi & (state == REQ);
      winner      = lowestId(pending);
      pendingNext = '0;
      for (int i = 0; i < NUM_EXT; i++) begin
         if (EDGE_MASK[i]) begin
            // a fresh edge beats a same-cycle ack or W1C clear
            pendingNext[i] = (externalInterrupts[i] & ~extPrev[i] & enable[i])
                           | (pending[i]
                              & ~(maskAck && bus.irq_id == 5'(i + 1))
                              & ~(bus.reg_write && bus.reg_addr == 2'd1 && bus.reg_wdata[i]));
         end else begin
            pendingNext[i] = externalInterrupts[i] & enable[i];
         end
      end
      pendingNext[NUM_EXT] = timerInterrupt & enable[NUM_EXT];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         enable        <= '0;
         pending       <= '0;
         extPrev       <= '0;
         nmiPrev       <= 1'b0;
         nmiPend       <= 1'b0;
         inService     <= '0;
         bus.irq_valid <= 1'b0;
         bus.irq_id    <= '0;
         bus.irq_nmi   <= 1'b0;
         bus.reg_rdata <= '0;
      end else begin
         pending <= pendingNext;
         extPrev <= externalInterrupts;
         nmiPrev <= NMI;

         if (bus.reg_write && bus.reg_addr == 2'd0) enable <= bus.reg_wdata[NUM_SRC-1:0];

         if (nmiAck) begin
            nmiPend     <= nmiEdge;
            bus.irq_nmi <= 1'b0;
         end else begin
            nmiPend     <= nmiPend | nmiEdge;
            bus.irq_nmi <= nmiPend;
         end

         if (bus.reg_read) begin
            case (bus.reg_addr)
               2'd0:    bus.reg_rdata <= 32'(enable);
               2'd1:    bus.reg_rdata <= 32'(pending);
               2'd2:    bus.reg_rdata <= (state == WAIT) ? 32'(inService) : 32'd0;
               default: bus.reg_rdata <= '0;
            endcase
         end

         case (state)
            IDLE: begin
               if (|pending) begin
                  state         <= REQ;
                  bus.irq_valid <= 1'b1;
                  bus.irq_id    <= winner;
               end
            end
            REQ: begin
               if (maskAck) begin
                  // irq_id holds the serviced id until WAIT is left
                  state         <= WAIT;
                  inService     <= bus.irq_id;
                  bus.irq_valid <= 1'b0;
               end else if (pending == '0) begin
                  state         <= IDLE;
                  bus.irq_valid <= 1'b0;
                  bus.irq_id    <= '0;
               end else begin
                  bus.irq_id <= winner;
               end
            end
            WAIT: begin
               if (bus.irq_complete && bus.complete_id == inService) begin
                  state         <= IDLE;
                  bus.irq_id    <= '0;
               end
            end
            default: begin
               state         <= IDLE;
               bus.irq_valid <= 1'b0;
               bus.irq_id    <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_irq_arbiter.sv
// Self-checking bench for irq_arbiter: directed scenarios plus random traffic,
// all compared every cycle against a behavioural reference model.
module tb_irq_arbiter;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] ext = '0;
   logic        timer = 1'b0;
   logic        nmi = 1'b0;

   int nChecks = 0;
   int nPass   = 0;

   irq_arbiter_if busIf();

   irq_arbiter #(.NUM_EXT(16), .EDGE_MASK(16'h0020)) dut (
      .clk(clk),
      .rst(rst),
      .externalInterrupts(ext),
      .timerInterrupt(timer),
      .NMI(nmi),
      .bus(busIf)
   );

   always #5 clk = ~clk;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChecks++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      else nPass++;
   endtask

   // ---------------- reference model ----------------
   bit [15:0]   edgeLines = 16'h0020;
   bit [16:0]   mEn;
   bit          mPend[17];
   bit          mPrev[16];
   bit          mNmiPrev, mNmiPend, mNmiOut;
   int          mPhase;          // 0 free, 1 offering, 2 handler running
   int          mId, mSvc;
   logic [31:0] mRdata;

   always @(posedge clk) begin : model
      bit        np[17];
      bit        ackN, ackM, nmiEv, w1c;
      int        lowP, nPhase, nId, nSvc;
      bit [31:0] packed17;
      if (rst) begin
         mEn = '0; mNmiPrev = 0; mNmiPend = 0; mNmiOut = 0;
         mPhase = 0; mId = 0; mSvc = 0; mRdata = '0;
         foreach (mPend[i]) mPend[i] = 0;
         foreach (mPrev[i]) mPrev[i] = 0;
      end else begin
         ackN  = busIf.irq_ack && mNmiOut;
         ackM  = busIf.irq_ack && !mNmiOut && mPhase == 1;
         nmiEv = nmi && !mNmiPrev;
         lowP = 0;
         for (int i = 16; i >= 0; i--) if (mPend[i]) lowP = i + 1;
         packed17 = '0;
         for (int i = 0; i < 17; i++) packed17[i] = mPend[i];
         for (int i = 0; i < 16; i++) begin
            if (edgeLines[i]) begin
               w1c = busIf.reg_write && busIf.reg_addr == 2'd1 && busIf.reg_wdata[i];
               np[i] = (ext[i] && !mPrev[i] && mEn[i]) ||
                       (mPend[i] && !(ackM && mId == i + 1) && !w1c);
            end else begin
               np[i] = ext[i] && mEn[i];
            end
         end
         np[16] = timer && mEn[16];
         if (busIf.reg_read) begin
            case (busIf.reg_addr)
               2'd0: mRdata = 32'(mEn);
               2'd1: mRdata = packed17;
               2'd2: mRdata = (mPhase == 2) ? 32'(mSvc) : 32'd0;
               default: mRdata = '0;
            endcase
         end
         nPhase = mPhase; nId = mId; nSvc = mSvc;
         if (mPhase == 0) begin
            if (lowP != 0) begin nPhase = 1; nId = lowP; end
         end else if (mPhase == 1) begin
            if (ackM) begin nPhase = 2; nSvc = mId; end
            else if (lowP == 0) begin nPhase = 0; nId = 0; end
            else nId = lowP;
         end else begin
            if (busIf.irq_complete && busIf.complete_id == mSvc) begin nPhase = 0; nId = 0; end
         end
         if (ackN) begin mNmiOut = 0; mNmiPend = nmiEv; end
         else begin mNmiOut = mNmiPend; mNmiPend = mNmiPend || nmiEv; end
         if (busIf.reg_write && busIf.reg_addr == 2'd0) mEn = busIf.reg_wdata[16:0];
         mPhase = nPhase; mId = nId; mSvc = nSvc;
         for (int i = 0; i < 17; i++) mPend[i] = np[i];
         for (int i = 0; i < 16; i++) mPrev[i] = ext[i];
         mNmiPrev = nmi;
      end
      #1;
      checkVal("m_valid", busIf.irq_valid, 32'(mPhase == 1));
      checkVal("m_id", busIf.irq_id, mId);
      checkVal("m_nmi", busIf.irq_nmi, 32'(mNmiOut));
      checkVal("m_rdata", busIf.reg_rdata, mRdata);
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic doReset();
      rst = 1'b1; ext = '0; timer = 0; nmi = 0;
      busIf.irq_ack = 0; busIf.irq_complete = 0; busIf.reg_write = 0; busIf.reg_read = 0;
      cyc(2);
      rst = 1'b0;
      cyc(1);
   endtask

   task automatic regWrite(input logic [1:0] a, input logic [31:0] d);
      busIf.reg_write = 1; busIf.reg_addr = a; busIf.reg_wdata = d;
      cyc(1);
      busIf.reg_write = 0;
   endtask

   task automatic regRead(input logic [1:0] a, output logic [31:0] d);
      busIf.reg_read = 1; busIf.reg_addr = a;
      cyc(1);
      busIf.reg_read = 0;
      d = busIf.reg_rdata;
   endtask

   task automatic pulseAck();
      busIf.irq_ack = 1;
      cyc(1);
      busIf.irq_ack = 0;
   endtask

   task automatic doComplete(input logic [4:0] id);
      busIf.irq_complete = 1; busIf.complete_id = id;
      cyc(1);
      busIf.irq_complete = 0;
   endtask

   initial begin : main
      logic [31:0] rd;
      busIf.reg_addr = '0; busIf.reg_wdata = '0; busIf.complete_id = '0;
      doReset();
      checkVal("rst_valid", busIf.irq_valid, 0);
      checkVal("rst_nmi", busIf.irq_nmi, 0);

      // level ext3
      regWrite(0, 32'h8);
      ext[3] = 1; cyc(2);
      checkVal("lvl_valid", busIf.irq_valid, 1);
      checkVal("lvl_id", busIf.irq_id, 4);
      pulseAck();
      checkVal("lvl_ackdrop", busIf.irq_valid, 0);
      checkVal("lvl_idhold", busIf.irq_id, 4);
      regRead(2, rd); checkVal("lvl_claim", rd, 4);
      doComplete(4); cyc(1);
      checkVal("lvl_reassert", busIf.irq_valid, 1);
      checkVal("lvl_reid", busIf.irq_id, 4);
      ext[3] = 0; cyc(3);
      checkVal("lvl_dropidle", busIf.irq_valid, 0);

      // priority
      doReset();
      regWrite(0, 32'h1FFFF);
      timer = 1; ext[7] = 1; cyc(2);
      checkVal("pri_id8", busIf.irq_id, 8);
      ext[0] = 1; cyc(2);
      checkVal("pri_id1", busIf.irq_id, 1);
      pulseAck();
      regRead(2, rd); checkVal("pri_claim", rd, 1);

      // edge line 5
      doReset();
      regWrite(0, 32'h20);
      ext[5] = 1; cyc(1); ext[5] = 0; cyc(2);
      regRead(1, rd); checkVal("edge_persist", rd, 32'h20);
      checkVal("edge_id", busIf.irq_id, 6);
      pulseAck();
      regRead(1, rd); checkVal("edge_ackclr", rd, 0);
      ext[5] = 1; regWrite(1, 32'h20); ext[5] = 0;
      regRead(1, rd); checkVal("edge_setwins", rd, 32'h20);
      regWrite(1, 32'h20);
      regRead(1, rd); checkVal("edge_w1c", rd, 0);

      // in-service lock
      doReset();
      regWrite(0, 32'h3);
      ext[1] = 1; cyc(2);
      checkVal("lock_id2", busIf.irq_id, 2);
      pulseAck();
      ext[0] = 1; cyc(3);
      checkVal("lock_held", busIf.irq_valid, 0);
      doComplete(9); cyc(2);
      checkVal("lock_badcmp", busIf.irq_valid, 0);
      regRead(2, rd); checkVal("lock_claim", rd, 2);
      doComplete(2); cyc(1);
      checkVal("lock_valid", busIf.irq_valid, 1);
      checkVal("lock_id1", busIf.irq_id, 1);

      // NMI during WAIT
      pulseAck();
      regWrite(0, 32'h0);
      nmi = 1; cyc(1);
      checkVal("nmi_lat1", busIf.irq_nmi, 0);
      cyc(1);
      checkVal("nmi_lat2", busIf.irq_nmi, 1);
      pulseAck();
      checkVal("nmi_ack", busIf.irq_nmi, 0);
      checkVal("nmi_novalid", busIf.irq_valid, 0);
      regRead(2, rd); checkVal("nmi_stillwait", rd, 1);
      nmi = 0; ext = '0;

      // reset mid-request
      doReset();
      regWrite(0, 32'h1);
      ext[0] = 1; cyc(2);
      checkVal("rreq_valid", busIf.irq_valid, 1);
      rst = 1; cyc(1);
      checkVal("rreq_valid0", busIf.irq_valid, 0);
      checkVal("rreq_id0", busIf.irq_id, 0);
      checkVal("rreq_rdata0", busIf.reg_rdata, 0);
      rst = 0; ext[0] = 0;
      regRead(0, rd); checkVal("rreq_enable", rd, 0);
      regRead(1, rd); checkVal("rreq_pending", rd, 0);

      // random traffic
      doReset();
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 3) == 0) ext[$urandom_range(0, 15)] ^= 1'b1;
         if ($urandom_range(0, 19) == 0) timer = ~timer;
         if ($urandom_range(0, 29) == 0) nmi = ~nmi;
         busIf.irq_ack = ($urandom_range(0, 2) == 0);
         busIf.irq_complete = ($urandom_range(0, 7) == 0);
         busIf.complete_id = ($urandom_range(0, 1) == 0) ? 5'(mSvc) : 5'($urandom_range(0, 17));
         busIf.reg_write = ($urandom_range(0, 9) == 0);
         busIf.reg_addr = 2'($urandom_range(0, 3));
         busIf.reg_wdata = ($urandom_range(0, 1) == 0) ? ($urandom() & 32'h1FFFF) : $urandom();
         busIf.reg_read = ($urandom_range(0, 3) == 0);
         rst = ($urandom_range(0, 499) == 0);
         cyc(1);
      end
      rst = 0;
      busIf.irq_ack = 0; busIf.irq_complete = 0; busIf.reg_write = 0; busIf.reg_read = 0;
      cyc(2);
      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
